// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - receive-side configurable CRC frame checker
//
// Purpose: consumes a frame of DWIDTH-bit words over a valid/ready handshake,
// computes the configured CRC over it, compares it to the CRC received with
// the last word and presents pass/fail, the finalized CRC and the word count
// over a second valid/ready handshake.
//
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   dataIn/dataValid/dataLast      frame words; byte 0 is the top byte, MSB first
//   rxCrc                          received CRC, sampled with the last word
//   dataReady                      checker can accept a word
//   frameAbort                     drop the current frame or pending result
//   genPoly/initValue              polynomial (implicit top bit omitted), initial value
//   refInEn/refOutEn               per-byte input reflection, output reflection
//   finalXorValue                  value XORed onto the (optionally reflected) CRC
//   resultValid/resultReady        result handshake
//   crcMatch/crcOut/wordCount      comparison result, finalized CRC, frame length

module crc_frame_checker #(
  parameter int CRC_WIDTH = 16,
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [DWIDTH-1:0]    dataIn,
  input  logic                 dataValid,
  input  logic                 dataLast,
  input  logic [CRC_WIDTH-1:0] rxCrc,
  output logic                 dataReady,
  input  logic                 frameAbort,
  input  logic [CRC_WIDTH-1:0] genPoly,
  input  logic [CRC_WIDTH-1:0] initValue,
  input  logic                 refInEn,
  input  logic                 refOutEn,
  input  logic [CRC_WIDTH-1:0] finalXorValue,
  output logic                 resultValid,
  input  logic                 resultReady,
  output logic                 crcMatch,
  output logic [CRC_WIDTH-1:0] crcOut,
  output logic [CNT_WIDTH-1:0] wordCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    CHECK  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t               state;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] poly_reg;
  logic                 ref_in_reg;
  logic                 ref_out_reg;
  logic [CRC_WIDTH-1:0] final_xor_reg;
  logic [CRC_WIDTH-1:0] rx_crc_reg;

  // Serial MSB-first CRC over one whole word, unrolled into one cycle.
  // With reflection, the LSB of each byte is fed first.
  function automatic logic [CRC_WIDTH-1:0] crc_word(
    input logic [CRC_WIDTH-1:0] crc_in,
    input logic [DWIDTH-1:0]    data,
    input logic [CRC_WIDTH-1:0] poly,
    input logic                 ref_in
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 bit_in;
    logic                 fb;
    c = crc_in;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      bit_in = ref_in ? data[(i / 8) * 8 + 7 - (i % 8)] : data[i];
      fb     = c[CRC_WIDTH-1] ^ bit_in;
      c      = (c << 1) ^ ({CRC_WIDTH{fb}} & poly);
    end
    return c;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bit_reverse(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) begin
      r[i] = v[CRC_WIDTH-1-i];
    end
    return r;
  endfunction

  logic                 beat;
  logic                 first_beat;
  logic [CRC_WIDTH-1:0] crc_next;
  logic [CRC_WIDTH-1:0] crc_final;

  assign beat       = dataValid & dataReady;
  assign first_beat = (state == IDLE);

  // The first word of a frame runs on the live config inputs; later words use
  // the copies latched on that first word.
  assign crc_next = crc_word(first_beat ? initValue : crc_reg,
                             dataIn,
                             first_beat ? genPoly : poly_reg,
                             first_beat ? refInEn : ref_in_reg);

  assign crc_final = (ref_out_reg ? bit_reverse(crc_reg) : crc_reg) ^ final_xor_reg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      dataReady     <= 1'b1;
      resultValid   <= 1'b0;
      crcMatch      <= 1'b0;
      crcOut        <= '0;
      wordCount     <= '0;
      crc_reg       <= '0;
      poly_reg      <= '0;
      ref_in_reg    <= 1'b0;
      ref_out_reg   <= 1'b0;
      final_xor_reg <= '0;
      rx_crc_reg    <= '0;
    end else if (frameAbort) begin
      // crcOut/crcMatch intentionally keep their stale values.
      state       <= IDLE;
      dataReady   <= 1'b1;
      resultValid <= 1'b0;
      wordCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            poly_reg      <= genPoly;
            ref_in_reg    <= refInEn;
            ref_out_reg   <= refOutEn;
            final_xor_reg <= finalXorValue;
            crc_reg       <= crc_next;
            wordCount     <= CNT_WIDTH'(1);
            if (dataLast) begin
              rx_crc_reg <= rxCrc;
              dataReady  <= 1'b0;
              state      <= CHECK;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (beat) begin
            crc_reg <= crc_next;
            if (wordCount != {CNT_WIDTH{1'b1}}) begin
              wordCount <= wordCount + CNT_WIDTH'(1);
            end
            if (dataLast) begin
              rx_crc_reg <= rxCrc;
              dataReady  <= 1'b0;
              state      <= CHECK;
            end
          end
        end
        CHECK: begin
          crcOut      <= crc_final;
          crcMatch    <= (crc_final == rx_crc_reg);
          resultValid <= 1'b1;
          state       <= RESULT;
        end
        RESULT: begin
          if (resultReady) begin
            resultValid <= 1'b0;
            dataReady   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          dataReady   <= 1'b1;
          resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb/tb_crc_frame_checker.sv - self-checking bench for crc_frame_checker (8-bit and 32-bit instances)
//
// Purpose: drives directed frames into a DWIDTH=8 and a DWIDTH=32 checker and
// compares every valid result against a bit-list CRC model of the frame.
// Ports: none (top-level bench).

module tb_crc_frame_checker;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] crc;
    logic        match;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rstN;

  logic [15:0] poly, init_v, xor_v;
  logic        ref_in, ref_out;
  logic        abort, rready;

  logic [7:0]  d8_data;
  logic        d8_valid, d8_last;
  logic [15:0] d8_rx;
  logic        ready8, rv8, match8;
  logic [15:0] crc8, cnt8;

  logic [31:0] d32_data;
  logic        d32_valid, d32_last;
  logic [15:0] d32_rx;
  logic        ready32, rv32, match32;
  logic [15:0] crc32, cnt32;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q32[$];

  crc_frame_checker #(.CRC_WIDTH(16), .DWIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .rstN(rstN),
    .dataIn(d8_data), .dataValid(d8_valid), .dataLast(d8_last), .rxCrc(d8_rx),
    .dataReady(ready8), .frameAbort(abort),
    .genPoly(poly), .initValue(init_v), .refInEn(ref_in), .refOutEn(ref_out),
    .finalXorValue(xor_v),
    .resultValid(rv8), .resultReady(rready),
    .crcMatch(match8), .crcOut(crc8), .wordCount(cnt8)
  );

  crc_frame_checker #(.CRC_WIDTH(16), .DWIDTH(32), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .rstN(rstN),
    .dataIn(d32_data), .dataValid(d32_valid), .dataLast(d32_last), .rxCrc(d32_rx),
    .dataReady(ready32), .frameAbort(abort),
    .genPoly(poly), .initValue(init_v), .refInEn(ref_in), .refOutEn(ref_out),
    .finalXorValue(xor_v),
    .resultValid(rv32), .resultReady(rready),
    .crcMatch(match32), .crcOut(crc32), .wordCount(cnt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC: flatten the frame into the bit sequence fed to the divider,
  // then do plain polynomial long division one bit at a time.
  function automatic logic [15:0] model_crc(input bq_t b, input logic [15:0] p,
                                            input logic [15:0] iv, input logic rin,
                                            input logic rout, input logic [15:0] x);
    logic        bits[$];
    logic [15:0] c;
    logic [15:0] r;
    logic        top;
    c = iv;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) bits.push_back(rin ? b[k][j] : b[k][7-j]);
    end
    foreach (bits[k]) begin
      top = c[15];
      c   = c << 1;
      if (top ^ bits[k]) c = c ^ p;
    end
    for (int i = 0; i < 16; i++) r[i] = rout ? c[15-i] : c[i];
    return r ^ x;
  endfunction

  function automatic bq_t digits();
    bq_t q;
    for (int i = 1; i <= 9; i++) q.push_back(8'(8'h30 + i));
    return q;
  endfunction

  function automatic bq_t zeros(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'h00);
    return q;
  endfunction

  task automatic push_exp(input int sel, input bq_t b, input logic [15:0] rx, input int nwords);
    exp_t e;
    e.crc   = model_crc(b, poly, init_v, ref_in, ref_out, xor_v);
    e.match = (e.crc == rx);
    e.cnt   = 16'(nwords);
    if (sel == 0) q8.push_back(e);
    else q32.push_back(e);
  endtask

  // Compare process: any valid result must equal the oldest expected result;
  // it retires on the edge where it is consumed or aborted.
  always @(negedge clk) begin
    if (rstN) begin
      if (rv8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv8_unexpected: got resultValid=1, expected 0");
        end else begin
          chk("cmp8_crc", 32'(crc8), 32'(q8[0].crc));
          chk("cmp8_match", 32'(match8), 32'(q8[0].match));
          chk("cmp8_cnt", 32'(cnt8), 32'(q8[0].cnt));
          chk("cmp8_ready_low", 32'(ready8), 32'd0);
          if (rready || abort) void'(q8.pop_front());
        end
      end
      if (rv32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv32_unexpected: got resultValid=1, expected 0");
        end else begin
          chk("cmp32_crc", 32'(crc32), 32'(q32[0].crc));
          chk("cmp32_match", 32'(match32), 32'(q32[0].match));
          chk("cmp32_cnt", 32'(cnt32), 32'(q32[0].cnt));
          chk("cmp32_ready_low", 32'(ready32), 32'd0);
          if (rready || abort) void'(q32.pop_front());
        end
      end
    end
  end

  task automatic wait_accept(input int sel);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = (sel == 0) ? ready8 : ready32;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 40) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got no dataReady in %0d cycles, expected acceptance", guard);
        acc = 1'b1;
      end
    end
  endtask

  // Sends the frame one word per accepted beat; rxCrc is only meaningful on
  // the last beat, so other beats carry a decoy value.
  task automatic send(input int sel, input bq_t b, input logic [15:0] rx, input bit with_last);
    int nw;
    bit lst;
    nw = (sel == 0) ? b.size() : b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      lst = with_last && (w == nw - 1);
      if (sel == 0) begin
        d8_data  = b[w];
        d8_valid = 1'b1;
        d8_last  = lst;
        d8_rx    = lst ? rx : 16'hDEAD;
      end else begin
        d32_data  = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
        d32_valid = 1'b1;
        d32_last  = lst;
        d32_rx    = lst ? rx : 16'hDEAD;
      end
      wait_accept(sel);
    end
    d8_valid  = 1'b0;
    d8_last   = 1'b0;
    d32_valid = 1'b0;
    d32_last  = 1'b0;
  endtask

  // Called right after the last beat's accepting edge: result must appear one
  // edge later, with the hand-computed values.
  task automatic expect_result(input int sel, input logic [15:0] crc_lit,
                               input logic match_lit, input logic [15:0] cnt_lit);
    @(negedge clk);
    chk("lat_early", 32'((sel == 0) ? rv8 : rv32), 32'd0);
    @(negedge clk);
    chk("lat_rise", 32'((sel == 0) ? rv8 : rv32), 32'd1);
    chk("lit_crc", 32'((sel == 0) ? crc8 : crc32), 32'(crc_lit));
    chk("lit_match", 32'((sel == 0) ? match8 : match32), 32'(match_lit));
    chk("lit_cnt", 32'((sel == 0) ? cnt8 : cnt32), 32'(cnt_lit));
  endtask

  task automatic consume(input int sel);
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("consume_rv_low", 32'((sel == 0) ? rv8 : rv32), 32'd0);
    chk("consume_ready_high", 32'((sel == 0) ? ready8 : ready32), 32'd1);
  endtask

  task automatic cfg(input logic [15:0] p, input logic [15:0] iv, input logic rin,
                     input logic rout, input logic [15:0] x);
    poly = p; init_v = iv; ref_in = rin; ref_out = rout; xor_v = x;
  endtask

  initial begin
    bq_t b;
    rstN = 1'b0; abort = 1'b0; rready = 1'b0;
    cfg(16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    d8_data = '0; d8_valid = 1'b0; d8_last = 1'b0; d8_rx = '0;
    d32_data = '0; d32_valid = 1'b0; d32_last = 1'b0; d32_rx = '0;

    // Pin the model against published check values.
    chk("model_ccitt", 32'(model_crc(digits(), 16'h1021, 16'hFFFF, 1'b0, 1'b0, 16'h0)), 32'h29B1);
    chk("model_arc", 32'(model_crc(digits(), 16'h8005, 16'h0000, 1'b1, 1'b1, 16'h0)), 32'hBB3D);
    chk("model_zero32", 32'(model_crc(zeros(8), 16'h1021, 16'h0000, 1'b0, 1'b0, 16'hFFFF)), 32'hFFFF);

    // Reset values.
    #12;
    chk("rst_ready8", 32'(ready8), 32'd1);
    chk("rst_rv8", 32'(rv8), 32'd0);
    chk("rst_match8", 32'(match8), 32'd0);
    chk("rst_crc8", 32'(crc8), 32'd0);
    chk("rst_cnt8", 32'(cnt8), 32'd0);
    chk("rst_ready32", 32'(ready32), 32'd1);
    chk("rst_rv32", 32'(rv32), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // CRC-16/CCITT-FALSE, 8-bit words.
    cfg(16'h1021, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    push_exp(0, digits(), 16'h29B1, 9);
    send(0, digits(), 16'h29B1, 1'b1);
    expect_result(0, 16'h29B1, 1'b1, 16'd9);
    consume(0);

    // CRC-16/ARC, matching and non-matching received CRC.
    cfg(16'h8005, 16'h0000, 1'b1, 1'b1, 16'h0000);
    push_exp(0, digits(), 16'hBB3D, 9);
    send(0, digits(), 16'hBB3D, 1'b1);
    expect_result(0, 16'hBB3D, 1'b1, 16'd9);
    consume(0);
    push_exp(0, digits(), 16'hBB3C, 9);
    send(0, digits(), 16'hBB3C, 1'b1);
    expect_result(0, 16'hBB3D, 1'b0, 16'd9);
    consume(0);

    // 32-bit words: two-word and single-word frames.
    cfg(16'h1021, 16'h0000, 1'b0, 1'b0, 16'hFFFF);
    push_exp(1, zeros(8), 16'hFFFF, 2);
    send(1, zeros(8), 16'hFFFF, 1'b1);
    expect_result(1, 16'hFFFF, 1'b1, 16'd2);
    consume(1);
    push_exp(1, zeros(4), 16'hFFFF, 1);
    send(1, zeros(4), 16'hFFFF, 1'b1);
    expect_result(1, 16'hFFFF, 1'b1, 16'd1);
    consume(1);

    // Backpressure: result held while the next frame's first word waits.
    cfg(16'h1021, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    push_exp(0, digits(), 16'h29B1, 9);
    send(0, digits(), 16'h29B1, 1'b1);
    expect_result(0, 16'h29B1, 1'b1, 16'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      d8_data = 8'h31; d8_valid = 1'b1; d8_last = 1'b0;
      @(negedge clk);
      chk("bp_ready_low", 32'(ready8), 32'd0);
      chk("bp_rv_high", 32'(rv8), 32'd1);
    end
    cfg(16'h8005, 16'h0000, 1'b1, 1'b1, 16'h0000);
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("bp_release_ready", 32'(ready8), 32'd1);
    push_exp(0, digits(), 16'hBB3D, 9);
    send(0, digits(), 16'hBB3D, 1'b1);
    expect_result(0, 16'hBB3D, 1'b1, 16'd9);
    consume(0);

    // Abort mid-frame with a beat in the abort cycle, then a full frame.
    cfg(16'h1021, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    b = '{8'h31, 8'h32, 8'h33};
    send(0, b, 16'h0, 1'b0);
    d8_data = 8'h34; d8_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; d8_valid = 1'b0;
    chk("abort_cnt", 32'(cnt8), 32'd0);
    chk("abort_ready", 32'(ready8), 32'd1);
    chk("abort_rv", 32'(rv8), 32'd0);
    push_exp(0, digits(), 16'h29B1, 9);
    send(0, digits(), 16'h29B1, 1'b1);
    expect_result(0, 16'h29B1, 1'b1, 16'd9);

    // Abort while the result is pending.
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_res_rv", 32'(rv8), 32'd0);
    chk("abort_res_cnt", 32'(cnt8), 32'd0);
    chk("abort_res_crc_kept", 32'(crc8), 32'h29B1);
    chk("abort_res_ready", 32'(ready8), 32'd1);

    // Asynchronous reset mid-frame, then a clean frame.
    send(0, digits(), 16'h0, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_ready", 32'(ready8), 32'd1);
    chk("arst_rv", 32'(rv8), 32'd0);
    chk("arst_cnt", 32'(cnt8), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    push_exp(0, digits(), 16'h29B1, 9);
    send(0, digits(), 16'h29B1, 1'b1);
    expect_result(0, 16'h29B1, 1'b1, 16'd9);
    consume(0);

    repeat (3) @(posedge clk);
    chk("queue8_drained", 32'(q8.size()), 32'd0);
    chk("queue32_drained", 32'(q32.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
